// File: rtl/arm_mem_pkg.sv
// rtl/arm_mem_pkg.sv - shared access-size encodings, LSU state type and byte-count helper
package arm_mem_pkg;

    localparam logic [1:0] SIZE_BYTE   = 2'b00;
    localparam logic [1:0] SIZE_HALF   = 2'b01;
    localparam logic [1:0] SIZE_WORD   = 2'b10;
    localparam logic [1:0] SIZE_DOUBLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        DONE  = 2'b11
    } lsu_state_t;

    // Number of bytes moved by an access of the given size encoding.
    function automatic logic [3:0] size_to_bytes(input logic [1:0] access_size);
        case (access_size)
            SIZE_BYTE: return 4'd1;
            SIZE_HALF: return 4'd2;
            SIZE_WORD: return 4'd4;
            default:   return 4'd8;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_unit.sv
// rtl/lsu_lane_unit.sv - load extract/extend and store byte-lane merge over one 8-byte line
import arm_mem_pkg::*;

module lsu_lane_unit (
    input  logic [1:0]  access_size,
    input  logic        sign_extend,
    input  logic [63:0] line,
    input  logic [63:0] store_data,
    output logic [63:0] load_value,
    output logic [63:0] merged_line
);

    logic [3:0] n_bytes;
    logic       msb;
    logic       fill;

    // Low N bytes come from the line (load) or from store_data (store); upper bytes are fill or old line.
    always_comb begin
        load_value  = '0;
        merged_line = '0;
        msb         = 1'b0;
        n_bytes     = size_to_bytes(access_size);
        case (access_size)
            SIZE_BYTE: msb = line[7];
            SIZE_HALF: msb = line[15];
            SIZE_WORD: msb = line[31];
            default:   msb = 1'b0;  // double: nothing above to extend into
        endcase
        fill = sign_extend & msb;
        for (int i = 0; i < 8; i++) begin
            if (i < int'(n_bytes)) begin
                load_value[8*i +: 8]  = line[8*i +: 8];
                merged_line[8*i +: 8] = store_data[8*i +: 8];
            end else begin
                load_value[8*i +: 8]  = {8{fill}};
                merged_line[8*i +: 8] = line[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - sized load/store initiator for an 8-byte-wide data memory
import arm_mem_pkg::*;

module load_store_unit #(
    parameter int size = 256
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        request,
    input  logic        is_store,
    input  logic [1:0]  access_size,
    input  logic        sign_extend,
    input  logic [63:0] address,
    input  logic [63:0] store_data,
    output logic        ready,
    output logic        done,
    output logic        fault,
    output logic [63:0] load_data,
    output logic        mem_read,
    output logic        mem_write,
    output logic [63:0] mem_address,
    output logic [63:0] mem_write_data,
    input  logic [63:0] mem_read_data
);

    // Highest legal start address: the full 8-byte line must fit in memory.
    localparam logic [63:0] LAST_START = 64'(size - 8);

    lsu_state_t  state, next_state;
    logic        accept;
    logic        out_of_range;
    logic        is_store_q;
    logic [1:0]  size_q;
    logic        sign_extend_q;
    logic [63:0] address_q;
    logic [63:0] store_data_q;
    logic [63:0] line_q;
    logic [63:0] lane_line;
    logic [63:0] load_value;
    logic [63:0] merged_line;

    assign accept       = request && (state == IDLE);
    assign out_of_range = address > LAST_START;

    // Loads extend straight off the memory bus so the result is ready on the READ->DONE edge.
    assign lane_line = (state == READ) ? mem_read_data : line_q;

    lsu_lane_unit u_lane (
        .access_size (size_q),
        .sign_extend (sign_extend_q),
        .line        (lane_line),
        .store_data  (store_data_q),
        .load_value  (load_value),
        .merged_line (merged_line)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= next_state;
    end

    // Next-state: faults skip memory entirely, narrow stores read the line first.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (request) begin
                    if (out_of_range)                     next_state = DONE;
                    else if (!is_store)                   next_state = READ;
                    else if (access_size == SIZE_DOUBLE)  next_state = WRITE;
                    else                                  next_state = READ;
                end
            end
            READ:    next_state = is_store_q ? WRITE : DONE;
            WRITE:   next_state = DONE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch, line buffer and registered load result.
    always_ff @(posedge clock) begin
        if (reset) begin
            is_store_q    <= 1'b0;
            size_q        <= SIZE_BYTE;
            sign_extend_q <= 1'b0;
            address_q     <= '0;
            store_data_q  <= '0;
            line_q        <= '0;
            load_data     <= '0;
            fault         <= 1'b0;
        end else begin
            if (accept) begin
                is_store_q    <= is_store;
                size_q        <= access_size;
                sign_extend_q <= sign_extend;
                address_q     <= address;
                store_data_q  <= store_data;
                fault         <= out_of_range;
            end
            if (state == READ) begin
                line_q <= mem_read_data;
                if (!is_store_q) load_data <= load_value;
            end
        end
    end

    assign ready          = (state == IDLE);
    assign done           = (state == DONE);
    assign mem_address    = address_q;
    assign mem_read       = (state == READ)  && !reset;
    assign mem_write      = (state == WRITE) && !reset;
    assign mem_write_data = (state == WRITE) ? merged_line : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit with a 256-byte memory model
module tb_load_store_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        request;
    logic        is_store;
    logic [1:0]  access_size;
    logic        sign_extend;
    logic [63:0] address;
    logic [63:0] store_data;
    logic        ready, done, fault;
    logic [63:0] load_data;
    logic        mem_read, mem_write;
    logic [63:0] mem_address, mem_write_data, mem_read_data;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mem [0:255];

    always #5 clock = ~clock;

    load_store_unit #(.size(256)) dut (
        .clock          (clock),
        .reset          (reset),
        .request        (request),
        .is_store       (is_store),
        .access_size    (access_size),
        .sign_extend    (sign_extend),
        .address        (address),
        .store_data     (store_data),
        .ready          (ready),
        .done           (done),
        .fault          (fault),
        .load_data      (load_data),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .mem_address    (mem_address),
        .mem_write_data (mem_write_data),
        .mem_read_data  (mem_read_data)
    );

    always_comb begin
        mem_read_data = '0;
        for (int i = 0; i < 8; i++)
            mem_read_data[8*i +: 8] = mem[8'(mem_address[7:0] + 8'(i))];
    end

    always @(posedge clock) begin
        if (mem_write)
            for (int i = 0; i < 8; i++)
                mem[8'(mem_address[7:0] + 8'(i))] <= mem_write_data[8*i +: 8];
    end

    function automatic logic [63:0] peek64(input logic [7:0] a);
        logic [63:0] v;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = mem[8'(a + 8'(i))];
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    int cyc;
    bit saw_rd, saw_wr;

    task automatic run_op(input logic st, input logic [1:0] sz, input logic sx,
                          input logic [63:0] a, input logic [63:0] d);
        @(negedge clock);
        request = 1'b1; is_store = st; access_size = sz; sign_extend = sx;
        address = a; store_data = d;
        @(posedge clock);
        @(negedge clock);
        request = 1'b0;
        cyc = 1; saw_rd = 1'b0; saw_wr = 1'b0;
        while (!done && cyc < 8) begin
            saw_rd |= mem_read;
            saw_wr |= mem_write;
            @(negedge clock);
            cyc++;
        end
        check("op_done_seen", 64'(done), 64'h1);
    endtask

    int n_done, n_ready;
    bit overlap;

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'h07;
        reset = 1'b1; request = 1'b0; is_store = 1'b0; access_size = 2'b00;
        sign_extend = 1'b0; address = '0; store_data = '0;
        repeat (2) @(negedge clock);
        check("rst_ready", 64'(ready), 64'h1);
        check("rst_done", 64'(done), 64'h0);
        check("rst_fault", 64'(fault), 64'h0);
        check("rst_load_data", load_data, 64'h0);
        check("rst_mem_read", 64'(mem_read), 64'h0);
        check("rst_mem_write", 64'(mem_write), 64'h0);
        check("rst_mem_address", mem_address, 64'h0);
        check("rst_mem_wdata", mem_write_data, 64'h0);
        reset = 1'b0;

        run_op(1'b0, 2'b11, 1'b0, 64'h10, 64'h0);
        check("ldur_cycles", 64'(cyc), 64'd2);
        check("ldur_data", load_data, 64'h0707070707070707);
        check("ldur_fault", 64'(fault), 64'h0);

        run_op(1'b1, 2'b11, 1'b0, 64'h20, 64'h8877665544332211);
        check("stur_cycles", 64'(cyc), 64'd2);
        check("stur_saw_read", 64'(saw_rd), 64'h0);
        check("stur_mem", peek64(8'h20), 64'h8877665544332211);

        run_op(1'b0, 2'b00, 1'b1, 64'h27, 64'h0);
        check("ldursb_data", load_data, 64'hFFFFFFFFFFFFFF88);
        run_op(1'b0, 2'b00, 1'b0, 64'h27, 64'h0);
        check("ldurb_data", load_data, 64'h0000000000000088);
        run_op(1'b0, 2'b10, 1'b1, 64'h24, 64'h0);
        check("ldursw_data", load_data, 64'hFFFFFFFF88776655);
        run_op(1'b0, 2'b01, 1'b1, 64'h22, 64'h0);
        check("ldursh_pos_data", load_data, 64'h0000000000004433);

        run_op(1'b1, 2'b00, 1'b0, 64'h41, 64'hFFFFFFFFFFFFFFAB);
        check("sturb_cycles", 64'(cyc), 64'd3);
        run_op(1'b0, 2'b11, 1'b0, 64'h40, 64'h0);
        check("sturb_readback", load_data, 64'h070707070707AB07);
        check("sturb_neighbour", peek64(8'h48), 64'h0707070707070707);

        run_op(1'b0, 2'b11, 1'b0, 64'hF9, 64'h0);
        check("oob_cycles", 64'(cyc), 64'd1);
        check("oob_fault", 64'(fault), 64'h1);
        check("oob_no_read", 64'(saw_rd), 64'h0);
        check("oob_no_write", 64'(saw_wr), 64'h0);
        check("oob_load_held", load_data, 64'h070707070707AB07);

        run_op(1'b0, 2'b11, 1'b0, 64'hF8, 64'h0);
        check("edge_addr_fault", 64'(fault), 64'h0);
        check("edge_addr_cycles", 64'(cyc), 64'd2);

        @(negedge clock);
        request = 1'b1; is_store = 1'b1; access_size = 2'b01; sign_extend = 1'b0;
        address = 64'h50; store_data = 64'hBEEF;
        @(posedge clock);
        @(negedge clock);
        request = 1'b0;
        check("sturh_read_phase", 64'(mem_read), 64'h1);
        @(negedge clock);
        check("sturh_write_phase", 64'(mem_write), 64'h1);
        reset = 1'b1;
        #1;
        check("sturh_write_gated", 64'(mem_write), 64'h0);
        @(negedge clock);
        reset = 1'b0;
        check("sturh_rst_no_done", 64'(done), 64'h0);
        check("sturh_rst_ready", 64'(ready), 64'h1);
        check("sturh_mem_untouched", peek64(8'h50), 64'h0707070707070707);

        @(negedge clock);
        request = 1'b1; is_store = 1'b0; access_size = 2'b11; address = 64'h10;
        @(posedge clock);
        n_done = 0; n_ready = 0; overlap = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (done) n_done++;
            if (ready) n_ready++;
            if (done && ready) overlap = 1'b1;
        end
        request = 1'b0;
        check("held_done_count", 64'(n_done), 64'd4);
        check("held_accept_count", 64'(n_ready), 64'd4);
        check("held_no_overlap", 64'(overlap), 64'h0);
        repeat (3) @(negedge clock);
        check("held_final_idle", 64'(ready), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
